datapath: RTL and testbench

Bus-based 32-bit CPU datapath for the phase-1 processor. It contains:
- a 16-entry general register file, PC, IR, Y, a 64-bit Z (ZHigh/ZLow), HI, LO, MAR, MDR and a sampled input port;
- a single shared 32-bit bus and a 16-function ALU.

An external control unit or testbench drives one-hot register-load enables, one-hot bus-source selects and the ALU opcode each cycle. The current bus value is exported for observation.

---
 rtl/datapath.sv | 137 +++++++++++++
 tb/tb_datapath.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Bus-based 32-bit CPU datapath: register file, special registers, shared bus and 16-function ALU.
// Optional macro DP_MULDIV_EN enables the signed multiplier/divider (opcodes 9 and 10).
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] enable,
  input  logic [31:0] busSelect,
  input  logic [31:0] inPort,
  input  logic [31:0] MDataIn,
  input  logic        MD_Read,
  input  logic [3:0]  Control_Signals,
  output logic [31:0] busMuxOut
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0]   gpr [16];
  logic [DATA_W-1:0]   pc, ir, y, hi, lo, mar, mdr, in_port_q;
  logic [2*DATA_W-1:0] z;

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   src [23];
  logic [2*DATA_W-1:0] alu_res;
  logic [2*DATA_W-1:0] ror_w, rol_w;
  logic [4:0]          shamt;
  logic signed [DATA_W-1:0] a_s;

  // Reserved select/enable bits and write-only registers (IR, MAR) have no reader here.
  logic unused_bits;
  assign unused_bits = ^{enable[31:24], busSelect[31:23], ir, mar};

`ifdef DP_MULDIV_EN
  function automatic logic [2*DATA_W-1:0] mul_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] a_x, b_x;
    a_x = $signed({{DATA_W{a[DATA_W-1]}}, a});
    b_x = $signed({{DATA_W{b[DATA_W-1]}}, b});
    return a_x * b_x;
  endfunction

  // Remainder takes the sign of the dividend; zero divisor and MIN/-1 are pinned explicitly.
  function automatic logic [2*DATA_W-1:0] div_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] q, r;
    if (b == '0) begin
      return {a, {DATA_W{1'b1}}};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {{DATA_W{1'b0}}, 32'h8000_0000};
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
  endfunction
`endif

  // Bus source table, index matches busSelect bit
  always_comb begin
    for (int i = 0; i < 16; i++) src[i] = gpr[i];
    src[16] = hi;
    src[17] = lo;
    src[18] = z[2*DATA_W-1:DATA_W];
    src[19] = z[DATA_W-1:0];
    src[20] = pc;
    src[21] = mdr;
    src[22] = in_port_q;
  end

  // Scan high to low so the lowest set bit wins
  always_comb begin
    bus = '0;
    for (int i = 22; i >= 0; i--) begin
      if (busSelect[i]) bus = src[i];
    end
  end

  assign busMuxOut = bus;

  assign shamt = bus[4:0];
  assign a_s   = $signed(y);
  assign ror_w = {y, y} >> shamt;
  assign rol_w = {y, y} << shamt;

  always_comb begin
    alu_res = '0;
    case (Control_Signals)
      4'd0:  alu_res = {{DATA_W{1'b0}}, y + bus};
      4'd1:  alu_res = {{DATA_W{1'b0}}, y - bus};
      4'd2:  alu_res = {{DATA_W{1'b0}}, y & bus};
      4'd3:  alu_res = {{DATA_W{1'b0}}, y | bus};
      4'd4:  alu_res = {{DATA_W{1'b0}}, y >> shamt};
      4'd5:  alu_res = {{DATA_W{1'b0}}, a_s >>> shamt};
      4'd6:  alu_res = {{DATA_W{1'b0}}, y << shamt};
      4'd7:  alu_res = {{DATA_W{1'b0}}, ror_w[DATA_W-1:0]};
      4'd8:  alu_res = {{DATA_W{1'b0}}, rol_w[2*DATA_W-1:DATA_W]};
`ifdef DP_MULDIV_EN
      4'd9:  alu_res = mul_fn(y, bus);
      4'd10: alu_res = div_fn(y, bus);
`endif
      4'd11: alu_res = {{DATA_W{1'b0}}, {DATA_W{1'b0}} - bus};
      4'd12: alu_res = {{DATA_W{1'b0}}, ~bus};
      4'd13: alu_res = {{DATA_W{1'b0}}, bus + 32'd1};
      4'd14: alu_res = {{DATA_W{1'b0}}, bus};
      default: alu_res = '0;
    endcase
  end

  // Register bank: clr wipes all state and overrides every enable
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      pc        <= '0;
      ir        <= '0;
      y         <= '0;
      z         <= '0;
      hi        <= '0;
      lo        <= '0;
      mar       <= '0;
      mdr       <= '0;
      in_port_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (enable[i]) gpr[i] <= bus;
      end
      if (enable[16]) pc  <= bus;
      if (enable[17]) ir  <= bus;
      if (enable[18]) y   <= bus;
      if (enable[19]) z   <= alu_res;
      if (enable[20]) hi  <= bus;
      if (enable[21]) lo  <= bus;
      if (enable[22]) mar <= bus;
      if (enable[23]) mdr <= MD_Read ? MDataIn : bus;
      in_port_q <= inPort;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; observes all state through busMuxOut.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] enable, busSelect, inPort, MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;

  int checks = 0;
  int errors = 0;

  datapath dut (
    .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect),
    .inPort(inPort), .MDataIn(MDataIn), .MD_Read(MD_Read),
    .Control_Signals(Control_Signals), .busMuxOut(busMuxOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, elo, ehi;
  } alu_vec_t;

  alu_vec_t basic_vecs [18] = '{
    '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0},
    '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0},
    '{4'd2,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 32'h0},
    '{4'd3,  32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 32'h0},
    '{4'd4,  32'h80000004, 32'h00000002, 32'h20000001, 32'h0},
    '{4'd5,  32'h80000004, 32'h00000002, 32'hE0000001, 32'h0},
    '{4'd6,  32'h80000004, 32'h00000002, 32'h00000010, 32'h0},
    '{4'd7,  32'h80000004, 32'h00000002, 32'h20000001, 32'h0},
    '{4'd8,  32'h80000004, 32'h00000002, 32'h00000012, 32'h0},
    '{4'd4,  32'h00001234, 32'h00000020, 32'h00001234, 32'h0},
    '{4'd7,  32'h00001234, 32'h00000020, 32'h00001234, 32'h0},
    '{4'd5,  32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 32'h0},
    '{4'd11, 32'h12345678, 32'h00000005, 32'hFFFFFFFB, 32'h0},
    '{4'd12, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h0},
    '{4'd13, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h0},
    '{4'd14, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0},
    '{4'd15, 32'h00000001, 32'h00000002, 32'h00000000, 32'h0},
    '{4'd0,  32'h00000007, 32'h00000008, 32'h0000000F, 32'h0}
  };

`ifdef DP_MULDIV_EN
  alu_vec_t md_vecs [6] = '{
    '{4'd9,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF},
    '{4'd9,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000},
    '{4'd10, 32'h00000011, 32'h00000005, 32'h00000003, 32'h00000002},
    '{4'd10, 32'h00000011, 32'h00000000, 32'hFFFFFFFF, 32'h00000011},
    '{4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000},
    '{4'd10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF}
  };
`else
  alu_vec_t md_vecs [2] = '{
    '{4'd9,  32'hFFFFFFFD, 32'h00000007, 32'h00000000, 32'h00000000},
    '{4'd10, 32'h00000011, 32'h00000005, 32'h00000000, 32'h00000000}
  };
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0;
    enable = '0;
    busSelect = '0;
    MD_Read = 1'b0;
    Control_Signals = 4'd0;
  endtask

  task automatic peek(input int sel, output logic [31:0] v);
    idle();
    busSelect = 32'h1 << sel;
    @(negedge clk);
    v = busMuxOut;
  endtask

  task automatic load_reg(input int bit_idx, input logic [31:0] v);
    idle();
    MDataIn = v;
    MD_Read = 1'b1;
    enable = 32'h1 << 23;
    tick();
    idle();
    busSelect = 32'h1 << 21;
    enable = 32'h1 << bit_idx;
    tick();
    idle();
  endtask

  task automatic run_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] zl, output logic [31:0] zh);
    load_reg(18, a);
    MDataIn = b;
    MD_Read = 1'b1;
    enable = 32'h1 << 23;
    tick();
    idle();
    busSelect = 32'h1 << 21;
    Control_Signals = op;
    enable = 32'h1 << 19;
    tick();
    peek(19, zl);
    peek(18, zh);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clr = 1'b1;
    enable = '0;
    busSelect = '0;
    MD_Read = 1'b0;
    Control_Signals = 4'd0;
    inPort = '0;
    MDataIn = '0;
    tick();
    for (int s = 0; s < 23; s++) begin
      peek(s, v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL reset_sel%0d: got %h exp %h", s, v, 32'h0);
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_nosel: got %h exp %h", busMuxOut, 32'h0);
    end
  endtask

  task automatic test_load_transfer();
    logic [31:0] v;
    idle();
    MDataIn = 32'h1;
    MD_Read = 1'b1;
    enable = 32'h1 << 23;
    tick();
    idle();
    busSelect = 32'h1 << 21;
    enable = 32'h1 << 3;
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h1) begin
      errors++;
      $display("FAIL xfer_bus: got %h exp %h", busMuxOut, 32'h1);
    end
    tick();
    peek(3, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL xfer_r3: got %h exp %h", v, 32'h1);
    end
  endtask

  task automatic test_shl();
    logic [31:0] v;
    load_reg(3, 32'h1);
    load_reg(5, 32'h2);
    busSelect = 32'h1 << 3;
    enable = 32'h1 << 18;
    tick();
    idle();
    busSelect = 32'h1 << 5;
    Control_Signals = 4'd6;
    enable = 32'h1 << 19;
    tick();
    idle();
    busSelect = 32'h1 << 19;
    enable = 32'h1 << 1;
    tick();
    peek(1, v);
    checks++;
    if (v !== 32'h4) begin
      errors++;
      $display("FAIL shl_r1: got %h exp %h", v, 32'h4);
    end
    peek(18, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL shl_zhigh: got %h exp %h", v, 32'h0);
    end
  endtask

  task automatic test_alu_basic();
    logic [31:0] zl, zh;
    for (int i = 0; i < 18; i++) begin
      run_alu(basic_vecs[i].op, basic_vecs[i].a, basic_vecs[i].b, zl, zh);
      checks++;
      if (zl !== basic_vecs[i].elo) begin
        errors++;
        $display("FAIL alu%0d_op%0d_zlow: got %h exp %h", i, basic_vecs[i].op, zl, basic_vecs[i].elo);
      end
      checks++;
      if (zh !== basic_vecs[i].ehi) begin
        errors++;
        $display("FAIL alu%0d_op%0d_zhigh: got %h exp %h", i, basic_vecs[i].op, zh, basic_vecs[i].ehi);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] zl, zh;
    foreach (md_vecs[i]) begin
      run_alu(md_vecs[i].op, md_vecs[i].a, md_vecs[i].b, zl, zh);
      checks++;
      if (zl !== md_vecs[i].elo) begin
        errors++;
        $display("FAIL md%0d_op%0d_zlow: got %h exp %h", i, md_vecs[i].op, zl, md_vecs[i].elo);
      end
      checks++;
      if (zh !== md_vecs[i].ehi) begin
        errors++;
        $display("FAIL md%0d_op%0d_zhigh: got %h exp %h", i, md_vecs[i].op, zh, md_vecs[i].ehi);
      end
    end
  endtask

  task automatic test_pc_increment();
    logic [31:0] v;
    load_reg(16, 32'h8);
    busSelect = 32'h1 << 20;
    Control_Signals = 4'd13;
    enable = (32'h1 << 19) | (32'h1 << 22);
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h8) begin
      errors++;
      $display("FAIL pcinc_bus: got %h exp %h", busMuxOut, 32'h8);
    end
    tick();
    idle();
    busSelect = 32'h1 << 19;
    enable = 32'h1 << 16;
    tick();
    peek(20, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("FAIL pcinc_pc: got %h exp %h", v, 32'h9);
    end
  endtask

  task automatic test_bus_priority();
    load_reg(2, 32'h0000AAAA);
    load_reg(9, 32'h00005555);
    load_reg(20, 32'h00001111);
    busSelect = (32'h1 << 9) | (32'h1 << 2) | (32'h1 << 21);
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL prio_low: got %h exp %h", busMuxOut, 32'h0000AAAA);
    end
    busSelect = (32'h1 << 22) | (32'h1 << 16);
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h00001111) begin
      errors++;
      $display("FAIL prio_hi: got %h exp %h", busMuxOut, 32'h00001111);
    end
    busSelect = (32'h1 << 23) | (32'h1 << 30);
    @(negedge clk);
    checks++;
    if (busMuxOut !== 32'h0) begin
      errors++;
      $display("FAIL prio_reserved: got %h exp %h", busMuxOut, 32'h0);
    end
    idle();
  endtask

  task automatic test_multi_and_self_load();
    logic [31:0] v;
    load_reg(6, 32'h00000077);
    busSelect = 32'h1 << 6;
    enable = (32'h1 << 6) | (32'h1 << 7);
    tick();
    peek(6, v);
    checks++;
    if (v !== 32'h77) begin
      errors++;
      $display("FAIL self_r6: got %h exp %h", v, 32'h77);
    end
    peek(7, v);
    checks++;
    if (v !== 32'h77) begin
      errors++;
      $display("FAIL multi_r7: got %h exp %h", v, 32'h77);
    end
    inPort = 32'hCAFEF00D;
    idle();
    tick();
    peek(22, v);
    checks++;
    if (v !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL inport: got %h exp %h", v, 32'hCAFEF00D);
    end
  endtask

  task automatic test_clear();
    logic [31:0] v, zl, zh;
    load_reg(1, 32'h5);
    run_alu(4'd0, 32'h3, 32'h4, zl, zh);
    load_reg(21, 32'h0BAD0BAD);
    idle();
    clr = 1'b1;
    MDataIn = 32'h12345678;
    MD_Read = 1'b1;
    busSelect = 32'h1 << 21;
    enable = (32'h1 << 1) | (32'h1 << 23) | (32'h1 << 19);
    tick();
    idle();
    busSelect = 32'h1 << 22;
    #1;
    checks++;
    if (busMuxOut !== 32'h0) begin
      errors++;
      $display("FAIL clr_inport: got %h exp %h", busMuxOut, 32'h0);
    end
    inPort = 32'h0;
    for (int s = 0; s < 22; s++) begin
      peek(s, v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL clr_sel%0d: got %h exp %h", s, v, 32'h0);
      end
    end
  endtask

  task automatic test_clr_midsequence();
    logic [31:0] v;
    load_reg(18, 32'h5);
    idle();
    clr = 1'b1;
    tick();
    idle();
    MDataIn = 32'h3;
    MD_Read = 1'b1;
    enable = 32'h1 << 23;
    tick();
    idle();
    busSelect = 32'h1 << 21;
    Control_Signals = 4'd0;
    enable = 32'h1 << 19;
    tick();
    peek(19, v);
    checks++;
    if (v !== 32'h3) begin
      errors++;
      $display("FAIL clr_mid_zlow: got %h exp %h", v, 32'h3);
    end
  endtask

  initial begin
    test_reset();
    test_load_transfer();
    test_shl();
    test_alu_basic();
    test_muldiv();
    test_pc_increment();
    test_bus_priority();
    test_multi_and_self_load();
    test_clear();
    test_clr_midsequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
